pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h8000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter IRQ_VEC, default 32'h8000_0004, meaning interrupt entry address.
REQ-003 SHALL have parameter EXC_VEC, default 32'h8000_0008, meaning illegal-instruction entry address.
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have port stall  in  1  high = hold all architectural state this cycle.
REQ-007 SHALL have port PCSrc  in  3  next-PC select from the decoder.
REQ-008 SHALL have port ALUOut0  in  1  branch-taken flag from ALU compare.
REQ-009 SHALL have port Imm16  in  16  branch offset, Instruction[15:0].
REQ-010 SHALL have port JT  in  26  jump target, Instruction[25:0].
REQ-011 SHALL have port DatabusA  in  32  rs value for jr/jalr.
REQ-012 SHALL have port irq_in  in  1  peripheral interrupt request, level.
REQ-013 SHALL have port PC  out  32  current instruction address.
REQ-014 SHALL have port PC_plus4  out  32  link value for jal/jalr.
REQ-015 SHALL have port supervisor  out  1  equal to PC[31].
REQ-016 SHALL have port IRQ  out  1  pending-interrupt flag to the decoder.
REQ-017 SHALL have port EPC  out  32  saved return address of last trap.

Function
REQ-018 SHALL compute PC_plus4 combinationally as {PC[31], PC[30:0]+4}; lower 31 bits wrap, bit 31 never changes.
REQ-019 SHALL compute branch target as {PC[31], PC_plus4[30:0] + (sign-extended Imm16 << 2)[30:0]}, bit 31 preserved.
REQ-020 SHALL select next PC by PCSrc: 000 PC_plus4; 001 branch target if ALUOut0=1 else PC_plus4; 010 {PC[31:28], JT, 2'b00}; 011 {PC[31] & DatabusA[31], DatabusA[30:0]}; 100 IRQ_VEC; 101 EXC_VEC.
REQ-021 SHALL treat PCSrc 110 and 111 identically to 101.
REQ-022 SHALL load PC with next PC on each rising edge where stall=0; stall=1 holds PC, EPC and pending-clear.
REQ-023 SHALL register irq_in into irq_d every cycle regardless of stall; rising edge = irq_in & ~irq_d.
REQ-024 SHALL set the pending flag on a detected rising edge, and clear it on an edge where stall=0 and PCSrc=100.
REQ-025 SHALL, when set and clear coincide, leave pending set (new request never lost).
REQ-026 SHALL drive IRQ = pending with zero added latency; supervisor gating is done downstream.
REQ-027 SHALL load EPC with PC on an accepted PCSrc=100 (interrupted instruction re-executes) and with PC_plus4 on an accepted 101/110/111; otherwise hold.
REQ-028 SHALL never allow jr/jalr to set PC[31] from 0 to 1; only reset, 100, 101 enter supervisor.

Reset
REQ-029 SHALL, while reset=0, asynchronously force PC=RESET_VEC, EPC=0, pending=0, irq_d=0, regardless of clk or stall.
REQ-030 SHALL resume on the first rising edge after reset deasserts, using next-PC from RESET_VEC.
REQ-031 SHALL, on reset mid-trap, discard any pending request; an irq_in still high after reset is not a new edge until it falls and rises again.

Verification
REQ-032 Reset then 3 cycles PCSrc=000 -> PC 8000_0000, 8000_0004, 8000_0008, 8000_000C; supervisor=1.
REQ-033 PC=0000_0100, PCSrc=001, Imm16=FFFE, ALUOut0=1 -> PC=0000_00FC; same with ALUOut0=0 -> 0000_0104.
REQ-034 PC=0000_0040, PCSrc=011, DatabusA=8000_1234 -> PC=0000_1234; from PC=8000_0040 -> 8000_1234.
REQ-035 PC=0000_0200, irq_in 0->1 -> IRQ=1 next cycle; with PCSrc=100 accepted -> PC=8000_0004, EPC=0000_0200, IRQ=0 while irq_in stays high.
REQ-036 PC=0000_0300, PCSrc=101 with stall=1 for 2 cycles then 0 -> PC holds 0000_0300 twice, then 8000_0008, EPC=0000_0304.
REQ-037 PC=7FFF_FFFC, PCSrc=000 -> PC=0000_0000; PC=FFFF_FFFC -> PC=8000_0000.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if -- bundle between the instruction decoder / datapath and the PC unit.
// The master side (decoder) drives next-PC selection, branch/jump operands, stall
// and the raw interrupt line; the slave side (pc_unit) returns PC, the link value,
// the supervisor bit, the pending-interrupt flag and the saved trap return address.
//   stall      : hold all architectural state this cycle
//   PCSrc      : next-PC select
//   ALUOut0    : branch-taken flag
//   Imm16      : branch offset (word units)
//   JT         : jump target (word units)
//   DatabusA   : register value for jr/jalr
//   irq_in     : peripheral interrupt request, level
//   PC         : current instruction address
//   PC_plus4   : link value
//   supervisor : PC[31]
//   IRQ        : pending interrupt
//   EPC        : return address of the last trap
interface pc_unit_if;
    logic        stall;
    logic [2:0]  PCSrc;
    logic        ALUOut0;
    logic [15:0] Imm16;
    logic [25:0] JT;
    logic [31:0] DatabusA;
    logic        irq_in;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        supervisor;
    logic        IRQ;
    logic [31:0] EPC;

    modport master (
        output stall, PCSrc, ALUOut0, Imm16, JT, DatabusA, irq_in,
        input  PC, PC_plus4, supervisor, IRQ, EPC
    );

    modport slave (
        input  stall, PCSrc, ALUOut0, Imm16, JT, DatabusA, irq_in,
        output PC, PC_plus4, supervisor, IRQ, EPC
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit -- program counter, next-PC selection, interrupt edge capture and EPC.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pc_unit_if.slave (see pc_unit_if.sv for the signal list)
// PC[31] is the supervisor bit. Sequential increments and branches never touch
// it; a register jump can only clear it; only reset and the two trap vectors set it.
module pc_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input logic        clk,
    input logic        reset,
    pc_unit_if.slave   bus
);

    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic        pending;
    logic        irq_d;
    logic        irq_mask;

    logic [31:0] pc_plus4;
    logic [31:0] imm_sh;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        irq_rise;
    logic        irq_taken;

    assign pc_plus4  = {pc_q[31], pc_q[30:0] + 31'd4};
    assign imm_sh    = {{14{bus.Imm16[15]}}, bus.Imm16, 2'b00};
    assign br_target = {pc_q[31], pc_plus4[30:0] + imm_sh[30:0]};

    always_comb begin
        next_pc = pc_plus4;
        case (bus.PCSrc)
            3'b000:  next_pc = pc_plus4;
            3'b001:  next_pc = bus.ALUOut0 ? br_target : pc_plus4;
            3'b010:  next_pc = {pc_q[31:28], bus.JT, 2'b00};
            3'b011:  next_pc = {pc_q[31] & bus.DatabusA[31], bus.DatabusA[30:0]};
            3'b100:  next_pc = IRQ_VEC;
            default: next_pc = EXC_VEC;
        endcase
    end

    // irq_mask is high only for the first clock after reset: a level that is
    // already present when reset releases is not treated as a new request.
    assign irq_rise  = bus.irq_in & ~irq_d & ~irq_mask;
    assign irq_taken = ~bus.stall & (bus.PCSrc == 3'b100);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VEC;
            epc_q    <= 32'h0;
            pending  <= 1'b0;
            irq_d    <= 1'b0;
            irq_mask <= 1'b1;
        end else begin
            irq_d    <= bus.irq_in;
            irq_mask <= 1'b0;
            // a new edge wins over a simultaneous acknowledge
            pending  <= irq_rise | (pending & ~irq_taken);
            if (!bus.stall) begin
                pc_q <= next_pc;
                if (bus.PCSrc == 3'b100)
                    epc_q <= pc_q;
                else if (bus.PCSrc[2])
                    epc_q <= pc_plus4;
            end
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PC_plus4   = pc_plus4;
    assign bus.supervisor = pc_q[31];
    assign bus.IRQ        = pending;
    assign bus.EPC        = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- scoreboard bench for pc_unit: a stimulus process drives one
// instruction per cycle and pushes the reference model's post-edge state; a
// monitor pops and compares on every falling edge.
module tb_pc_unit;
    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if pif();

    pc_unit #(.RESET_VEC(RV), .IRQ_VEC(IV), .EXC_VEC(EV)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (pif.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic        s_rst, s_stall, s_alu, s_irq;
    logic [2:0]  s_src;
    logic [15:0] s_imm;
    logic [25:0] s_jt;
    logic [31:0] s_a;

    logic [31:0] m_pc, m_epc;
    logic        m_pend, m_prev, m_fresh;

    // add an offset to the low 31 bits modulo 2^31, keeping bit 31
    function automatic logic [31:0] lo_add(logic [31:0] base, longint off);
        longint v;
        v = longint'(base & 32'h7fff_ffff) + off;
        v = v % 64'sd2147483648;
        if (v < 0) v = v + 64'sd2147483648;
        return {base[31], v[30:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] p4, nxt;
        logic rise;
        if (!s_rst) begin
            m_pc = RV; m_epc = 32'h0; m_pend = 1'b0; m_prev = 1'b0; m_fresh = 1'b1;
        end else begin
            p4 = lo_add(m_pc, 4);
            case (int'(s_src))
                0: nxt = p4;
                1: nxt = s_alu ? lo_add(p4, longint'($signed(s_imm)) * 4) : p4;
                2: nxt = (m_pc & 32'hF000_0000) | ({6'b0, s_jt} * 4);
                3: nxt = (m_pc[31] && s_a[31]) ? s_a : (s_a & 32'h7fff_ffff);
                4: nxt = IV;
                default: nxt = EV;
            endcase
            rise = s_irq && !m_prev && !m_fresh;
            m_pend = rise || (m_pend && !(!s_stall && s_src == 3'd4));
            if (!s_stall) begin
                if (s_src == 3'd4) m_epc = m_pc;
                else if (s_src >= 3'd5) m_epc = p4;
                m_pc = nxt;
            end
            m_prev = s_irq;
            m_fresh = 1'b0;
        end
        exp_q.push_back('{pc: m_pc, epc: m_epc, irq: m_pend});
    endtask

    task automatic step();
        logic was_high;
        @(negedge clk);
        #1;
        was_high      = rst;
        rst           = s_rst;
        pif.stall     = s_stall;
        pif.PCSrc     = s_src;
        pif.ALUOut0   = s_alu;
        pif.Imm16     = s_imm;
        pif.JT        = s_jt;
        pif.DatabusA  = s_a;
        pif.irq_in    = s_irq;
        if (was_high && !s_rst) begin
            #1;
            chk("async_rst_pc", pif.PC, RV);
            chk("async_rst_epc", pif.EPC, 32'h0);
            chk("async_rst_irq", {31'b0, pif.IRQ}, 32'h0);
        end
        model_step();
    endtask

    task automatic go(input logic [2:0] src, input logic [31:0] a);
        s_rst = 1'b1; s_stall = 1'b0; s_src = src; s_a = a;
        s_alu = 1'b0; s_imm = 16'h0; s_jt = 26'h0;
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pif.PC, e.pc);
                chk("epc", pif.EPC, e.epc);
                chk("irq", {31'b0, pif.IRQ}, {31'b0, e.irq});
                chk("pc_plus4", pif.PC_plus4, lo_add(e.pc, 4));
                chk("supervisor", {31'b0, pif.supervisor}, {31'b0, e.pc[31]});
            end
        end
    end

    initial begin : stimulus
        s_rst = 1'b0; s_stall = 1'b0; s_alu = 1'b0; s_irq = 1'b0;
        s_src = 3'd0; s_imm = 16'h0; s_jt = 26'h0; s_a = 32'h0;
        pif.stall = 1'b0; pif.PCSrc = 3'd0; pif.ALUOut0 = 1'b0; pif.Imm16 = 16'h0;
        pif.JT = 26'h0; pif.DatabusA = 32'h0; pif.irq_in = 1'b0;

        step(); step();
        repeat (3) go(3'd0, 32'h0);

        go(3'd3, 32'h0000_0100);
        s_src = 3'd1; s_imm = 16'hFFFE; s_alu = 1'b1; step();
        go(3'd3, 32'h0000_0100);
        s_src = 3'd1; s_imm = 16'hFFFE; s_alu = 1'b0; step();
        s_src = 3'd2; s_jt = 26'h3FF_FFFF; step();

        go(3'd3, 32'h0000_0040);
        go(3'd3, 32'h8000_1234);
        go(3'd5, 32'h0);
        go(3'd3, 32'h8000_0040);
        go(3'd3, 32'h8000_1234);

        go(3'd3, 32'h0000_0200);
        s_irq = 1'b1; s_stall = 1'b1; step();
        go(3'd4, 32'h0);
        go(3'd0, 32'h0);
        s_irq = 1'b0; go(3'd0, 32'h0);
        s_irq = 1'b1; go(3'd4, 32'h0);
        go(3'd4, 32'h0);

        go(3'd3, 32'h0000_0300);
        s_src = 3'd5; s_stall = 1'b1; step();
        s_src = 3'd5; s_stall = 1'b1; step();
        go(3'd5, 32'h0);
        go(3'd6, 32'h0);
        go(3'd7, 32'h0);

        go(3'd3, 32'h7FFF_FFFC);
        go(3'd0, 32'h0);
        go(3'd5, 32'h0);
        go(3'd3, 32'hFFFF_FFFC);
        go(3'd0, 32'h0);

        s_irq = 1'b1; go(3'd0, 32'h0);
        s_rst = 1'b0; s_stall = 1'b1; step();
        s_rst = 1'b0; step();
        go(3'd0, 32'h0);
        go(3'd0, 32'h0);
        s_irq = 1'b0; go(3'd0, 32'h0);
        s_irq = 1'b1; go(3'd0, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            s_rst   = ($urandom_range(0, 199) != 0);
            s_stall = ($urandom_range(0, 3) == 0);
            s_src   = 3'($urandom_range(0, 7));
            s_alu   = 1'($urandom);
            s_imm   = 16'($urandom);
            s_jt    = 26'($urandom);
            s_a     = $urandom;
            if ($urandom_range(0, 4) == 0) s_irq = ~s_irq;
            step();
        end

        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
